// File: rtl/menor_pkg.sv
// Shared state encoding for the windowed-minimum finder.
package menor_pkg;

   localparam int ESTADO_W = 2;

   typedef enum logic [ESTADO_W-1:0] {
      VAZIO   = 2'd0,
      ACUMULA = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

endpackage

// File: rtl/comparador_menor.sv
// Combinational a-vs-b comparator: a strictly less than b, and a equal to b.
// Define MENOR_SINAL_EN for two's-complement ordering; unsigned otherwise.
module comparador_menor #(
   parameter int LARGURA = 10
) (
   input  logic [LARGURA-1:0] a_i,
   input  logic [LARGURA-1:0] b_i,
   output logic               menor_o,
   output logic               igual_o
);

`ifdef MENOR_SINAL_EN
   assign menor_o = $signed(a_i) < $signed(b_i);
`else
   assign menor_o = a_i < b_i;
`endif

   assign igual_o = (a_i == b_i);

endmodule

// File: rtl/menor_janela.sv
// Streaming windowed minimum: one result (min, first index, tie) per JANELA samples.
// Signed comparison when MENOR_SINAL_EN is defined, unsigned otherwise.
module menor_janela
   import menor_pkg::*;
#(
   parameter int LARGURA = 10,
   parameter int JANELA  = 8,
   parameter int IDXW    = $clog2(JANELA)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valido,
   output logic               in_pronto,
   input  logic [LARGURA-1:0] in_dado,
   output logic               out_valido,
   input  logic               out_pronto,
   output logic [LARGURA-1:0] out_menor,
   output logic [IDXW-1:0]    out_indice,
   output logic               out_empate
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   estado_t              estado_q;
   logic [IDXW-1:0]      cont_q;
   logic [LARGURA-1:0]   menor_q, menor_d, out_menor_q;
   logic [IDXW-1:0]      indice_q, indice_d, out_indice_q;
   logic                 empate_q, empate_d, out_empate_q;
   logic                 cmp_menor, cmp_igual;
   logic                 in_xfer, out_xfer, ultima;

   comparador_menor #(.LARGURA(LARGURA)) u_cmp (
      .a_i     (in_dado),
      .b_i     (menor_q),
      .menor_o (cmp_menor),
      .igual_o (cmp_igual)
   );

   assign in_pronto  = (estado_q == ENTREGA) ? out_pronto : 1'b1;
   assign out_valido = (estado_q == ENTREGA);
   assign in_xfer    = in_valido && in_pronto;
   assign out_xfer   = out_valido && out_pronto;
   assign ultima     = (cont_q == IDXW'(JANELA - 1));

   assign out_menor  = out_menor_q;
   assign out_indice = out_indice_q;
   assign out_empate = out_empate_q;

   // Running result including the current sample; first occurrence of the minimum wins.
   always_comb begin
      menor_d  = menor_q;
      indice_d = indice_q;
      empate_d = empate_q;
      if (cmp_menor) begin
         menor_d  = in_dado;
         indice_d = cont_q;
         empate_d = 1'b0;
      end else if (cmp_igual) begin
         empate_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q     <= VAZIO;
         cont_q       <= '0;
         menor_q      <= '0;
         indice_q     <= '0;
         empate_q     <= 1'b0;
         out_menor_q  <= '0;
         out_indice_q <= '0;
         out_empate_q <= 1'b0;
      end else begin
         case (estado_q)
            VAZIO: begin
               if (in_xfer) begin
                  menor_q  <= in_dado;
                  indice_q <= '0;
                  empate_q <= 1'b0;
                  cont_q   <= IDXW'(1);
                  estado_q <= ACUMULA;
               end
            end
            ACUMULA: begin
               if (in_xfer) begin
                  menor_q  <= menor_d;
                  indice_q <= indice_d;
                  empate_q <= empate_d;
                  if (ultima) begin
                     cont_q       <= '0;
                     out_menor_q  <= menor_d;
                     out_indice_q <= indice_d;
                     out_empate_q <= empate_d;
                     estado_q     <= ENTREGA;
                  end else begin
                     cont_q <= cont_q + IDXW'(1);
                  end
               end
            end
            ENTREGA: begin
               // A sample arriving with the result handoff opens the next window at once.
               if (out_xfer) begin
                  if (in_xfer) begin
                     menor_q  <= in_dado;
                     indice_q <= '0;
                     empate_q <= 1'b0;
                     cont_q   <= IDXW'(1);
                     estado_q <= ACUMULA;
                  end else begin
                     estado_q <= VAZIO;
                  end
               end
            end
            default: estado_q <= VAZIO;
         endcase
      end
   end

endmodule

// File: tb/tb_menor_janela.sv
// Self-checking bench for menor_janela: directed cases plus randomized stalls vs. a window model.
module tb_menor_janela;

   localparam int LARGURA = 10;
   localparam int JANELA  = 8;
   localparam int IDXW    = 3;
   localparam int RW      = 1 + IDXW + LARGURA;

`ifdef MENOR_SINAL_EN
   localparam logic [LARGURA-1:0] T2_MENOR  = 10'h200;
   localparam logic [IDXW-1:0]    T2_INDICE = 3'd2;
`else
   localparam logic [LARGURA-1:0] T2_MENOR  = 10'h001;
   localparam logic [IDXW-1:0]    T2_INDICE = 3'd3;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valido = 1'b0;
   logic               in_pronto;
   logic [LARGURA-1:0] in_dado = '0;
   logic               out_valido;
   logic               out_pronto = 1'b0;
   logic [LARGURA-1:0] out_menor;
   logic [IDXW-1:0]    out_indice;
   logic               out_empate;

   int checks = 0;
   int errors = 0;
   int n_res  = 0;

   logic [LARGURA-1:0] win_q[$];
   logic [RW-1:0]      exp_q[$];
   logic [RW-1:0]      got_q[$];
   logic               s_in_pronto, s_out_valido;

   menor_janela #(.LARGURA(LARGURA), .JANELA(JANELA)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valido  (in_valido),
      .in_pronto  (in_pronto),
      .in_dado    (in_dado),
      .out_valido (out_valido),
      .out_pronto (out_pronto),
      .out_menor  (out_menor),
      .out_indice (out_indice),
      .out_empate (out_empate)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic menor_que(input logic [LARGURA-1:0] a, input logic [LARGURA-1:0] b);
`ifdef MENOR_SINAL_EN
      return $signed(a) < $signed(b);
`else
      return a < b;
`endif
   endfunction

   // Reference: scan the whole window, keep first minimum, count its occurrences.
   function automatic logic [RW-1:0] ref_janela();
      logic [LARGURA-1:0] m;
      int idx, n;
      m   = win_q[0];
      idx = 0;
      for (int i = 1; i < JANELA; i++)
         if (menor_que(win_q[i], m)) begin
            m   = win_q[i];
            idx = i;
         end
      n = 0;
      for (int i = 0; i < JANELA; i++)
         if (win_q[i] == m) n++;
      return {(n > 1), IDXW'(idx), m};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic iv, input logic [LARGURA-1:0] d, input logic op);
      logic [RW-1:0] got;
      @(negedge clk);
      in_valido  = iv;
      in_dado    = d;
      out_pronto = op;
      #1;
      s_in_pronto  = in_pronto;
      s_out_valido = out_valido;
      if (out_valido && op) begin
         got = {out_empate, out_indice, out_menor};
         got_q.push_back(got);
         n_res++;
         chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("sb_result", 32'(got), 32'(exp_q.pop_front()));
      end
      if (iv && in_pronto) begin
         win_q.push_back(d);
         if (win_q.size() == JANELA) begin
            exp_q.push_back(ref_janela());
            win_q.delete();
         end
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      in_valido  = 1'b1;
      in_dado    = '0;
      out_pronto = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst        = 1'b0;
      in_valido  = 1'b0;
      out_pronto = 1'b0;
      win_q.delete();
      exp_q.delete();
      #1;
      chk("rst_in_pronto", 32'(in_pronto), 32'd1);
      chk("rst_out_valido", 32'(out_valido), 32'd0);
      chk("rst_out_menor", 32'(out_menor), 32'd0);
      chk("rst_out_indice", 32'(out_indice), 32'd0);
      chk("rst_out_empate", 32'(out_empate), 32'd0);
      @(posedge clk);
   endtask

   initial begin
      int t1 [JANELA] = '{50, 40, 60, 40, 70, 30, 90, 30};
      int t2 [JANELA] = '{'h005, 'h3FF, 'h200, 'h001, 'h010, 'h010, 'h010, 'h010};
      int t5 [JANELA] = '{20, 15, 25, 15, 30, 40, 50, 60};
      int acc, cyc, n_res0;
      logic iv, op;
      logic [LARGURA-1:0] d;

      do_reset();

      // Window with a tie on the minimum, consumer always ready.
      got_q.delete();
      for (int i = 0; i < JANELA; i++) begin
         cycle(1'b1, LARGURA'(t1[i]), 1'b1);
         chk("t1_no_early_valid", 32'(s_out_valido), 32'd0);
         chk("t1_in_pronto", 32'(s_in_pronto), 32'd1);
      end
      cycle(1'b0, '0, 1'b1);
      chk("t1_latency", 32'(s_out_valido), 32'd1);
      chk("t1_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0)
         chk("t1_result", 32'(got_q[0]), 32'({1'b1, 3'd5, 10'd30}));
      cycle(1'b0, '0, 1'b1);
      chk("t1_valid_drop", 32'(s_out_valido), 32'd0);

      // Signed vs unsigned ordering.
      do_reset();
      got_q.delete();
      for (int i = 0; i < JANELA; i++) cycle(1'b1, LARGURA'(t2[i]), 1'b1);
      cycle(1'b0, '0, 1'b1);
      chk("t2_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0)
         chk("t2_result", 32'(got_q[0]), 32'({1'b0, T2_INDICE, T2_MENOR}));

      // Back-to-back descending ramp: every window minimum is its last sample.
      got_q.delete();
      for (int i = 0; i < 3 * JANELA; i++) begin
         cycle(1'b1, LARGURA'(3 * JANELA - 1 - i), 1'b1);
         chk("t3_no_bubble", 32'(s_in_pronto), 32'd1);
      end
      cycle(1'b0, '0, 1'b1);
      chk("t3_count", 32'(got_q.size()), 32'd3);
      for (int k = 0; k < 3; k++)
         if (k < got_q.size())
            chk("t3_result", 32'(got_q[k]), 32'({1'b0, 3'd7, LARGURA'(16 - 8 * k)}));

      // Backpressure: result held, input blocked, then handoff with a new sample.
      got_q.delete();
      for (int i = 0; i < JANELA; i++) cycle(1'b1, LARGURA'($urandom_range(50, 500)), 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, LARGURA'($urandom_range(0, 1023)), 1'b0);
         chk("t4_in_blocked", 32'(s_in_pronto), 32'd0);
         chk("t4_held_valid", 32'(s_out_valido), 32'd1);
         if (exp_q.size() > 0)
            chk("t4_stable", 32'({out_empate, out_indice, out_menor}), 32'(exp_q[0]));
      end
      cycle(1'b1, LARGURA'(3), 1'b1);
      chk("t4_handoff_ready", 32'(s_in_pronto), 32'd1);
      for (int i = 1; i < JANELA; i++) begin
         cycle(1'b1, LARGURA'(100 + i), 1'b1);
         chk("t4_next_window_pending", 32'(s_out_valido), 32'd0);
      end
      cycle(1'b0, '0, 1'b1);
      chk("t4_count", 32'(got_q.size()), 32'd2);
      if (got_q.size() > 1)
         chk("t4_next_result", 32'(got_q[1]), 32'({1'b0, 3'd0, 10'd3}));

      // Reset in mid-window discards the partial window.
      for (int i = 0; i < 4; i++) cycle(1'b1, LARGURA'(1), 1'b1);
      do_reset();
      got_q.delete();
      cycle(1'b0, '0, 1'b1);
      chk("t5_no_valid", 32'(s_out_valido), 32'd0);
      for (int i = 0; i < JANELA; i++) cycle(1'b1, LARGURA'(t5[i]), 1'b1);
      cycle(1'b0, '0, 1'b1);
      chk("t5_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0)
         chk("t5_result", 32'(got_q[0]), 32'({1'b1, 3'd1, 10'd15}));

      // Randomized stalls on both sides, 1000 windows.
      n_res0 = n_res;
      acc = 0;
      cyc = 0;
      while (acc < 1000 * JANELA && cyc < 60000) begin
         iv = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 1) != 0) ? LARGURA'($urandom_range(0, 1023))
                                          : LARGURA'($urandom_range(0, 3));
         cycle(iv, d, op);
         if (iv && s_in_pronto) acc++;
         cyc++;
      end
      chk("rnd_samples_within_bound", 32'(acc), 32'(1000 * JANELA));
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      chk("rnd_result_count", 32'(n_res - n_res0), 32'd1000);
      chk("rnd_sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
